// File: rtl/int_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : int_pkg
//  Description : Shared definitions for the interrupt controller.
//                - Controller state encoding
//                - Return-from-interrupt opcode retired by decode
//                - Default handler vector base and stride
//                - Lowest-set-bit helper used by the arbiter
//  Revision    : 1.0  initial release
// ============================================================================
package int_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    // Decode signals int_done when it retires this opcode.
    localparam logic [3:0]  INT_DONE_OP    = 4'b0011;

    localparam logic [15:0] DEF_VEC_BASE   = 16'h0F00;
    localparam logic [15:0] DEF_VEC_STRIDE = 16'h0010;

    // Index of the lowest set bit. The loop scans downward, so the last hit
    // is the lowest index. Returns 0 for an all-zero input; callers must
    // qualify the result with their own "any bit set" flag.
    function automatic logic [2:0] lowest_set(input logic [7:0] req);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/int_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : int_sync_edge
//  Description : Two-flop synchroniser for one asynchronous interrupt line,
//                followed by a rising-edge detector against a third flop.
//                edge_pulse is high for one clock per clean rising edge.
//  Ports       : clk        in  system clock
//                rst        in  asynchronous active-low reset
//                async_in   in  raw asynchronous input
//                edge_pulse out one-cycle rising-edge pulse (synchronous)
//  Revision    : 1.0  initial release
// ============================================================================
module int_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic edge_pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign edge_pulse = sync2_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : int_ctrl
//  Description : Interrupt controller beside fetch. Latches rising edges of
//                NUM_SRC external sources as pending, grants the lowest-index
//                pending unmasked source, requests a redirect to its handler,
//                saves the return PC on acceptance and releases it when
//                decode retires the return-from-interrupt opcode.
//  Ports       : clk, rst (async active-low)
//                src        raw interrupt lines
//                mask_we / mask_wdata   mask register write (1 = enabled)
//                int_req / int_vector / int_id   redirect request to fetch
//                int_ack / ack_pc       fetch acceptance and return address
//                int_done               handler finished (from decode)
//                ret_valid / ret_pc     one-cycle return redirect
//                pending                pending register (debug/LEDs)
//  Revision    : 1.0  initial release
// ============================================================================
module int_ctrl
    import int_pkg::*;
#(
    parameter int          NUM_SRC    = 4,
    parameter logic [15:0] VEC_BASE   = DEF_VEC_BASE,
    parameter logic [15:0] VEC_STRIDE = DEF_VEC_STRIDE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    output logic               int_req,
    output logic [15:0]        int_vector,
    output logic [2:0]         int_id,
    input  logic               int_ack,
    input  logic [15:0]        ack_pc,
    input  logic               int_done,
    output logic               ret_valid,
    output logic [15:0]        ret_pc,
    output logic [NUM_SRC-1:0] pending
);

    logic [NUM_SRC-1:0] src_edge;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            int_sync_edge u_sync_edge (
                .clk        (clk),
                .rst        (rst),
                .async_in   (src[gi]),
                .edge_pulse (src_edge[gi])
            );
        end
    endgenerate

    state_e             state_q,   state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q,    mask_d;
    logic [2:0]         id_q,      id_d;
    logic [15:0]        vector_q,  vector_d;
    logic [15:0]        ret_pc_q,  ret_pc_d;

    logic [NUM_SRC-1:0] eligible;
    logic [7:0]         eligible_ext;
    logic [2:0]         grant_id;
    logic               grant;
    logic [NUM_SRC-1:0] grant_clr;

    // Arbitration: masked sources stay pending but cannot win.
    always_comb begin
        eligible     = pending_q & mask_q;
        eligible_ext = 8'(eligible);
        grant_id     = lowest_set(eligible_ext);
        grant        = (state_q == ST_IDLE) && (eligible != '0);
        grant_clr    = grant ? (NUM_SRC'(1) << grant_id) : '0;
    end

    // A new edge in the grant cycle re-sets the bit being cleared.
    always_comb begin
        pending_d = (pending_q & ~grant_clr) | src_edge;
        mask_d    = mask_we ? mask_wdata : mask_q;
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        vector_d  = vector_q;
        ret_pc_d  = ret_pc_q;
        int_req   = 1'b0;
        ret_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    id_d     = grant_id;
                    vector_d = VEC_BASE + 16'(grant_id) * VEC_STRIDE;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                int_req = 1'b1;
                if (int_ack) begin
                    ret_pc_d = ack_pc;
                    state_d  = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                // No nesting: pending requests wait until we return to IDLE.
                if (int_done) begin
                    ret_valid = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            mask_q    <= '1;
            id_q      <= 3'd0;
            vector_q  <= 16'h0000;
            ret_pc_q  <= 16'h0000;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            id_q      <= id_d;
            vector_q  <= vector_d;
            ret_pc_q  <= ret_pc_d;
        end
    end

    assign int_vector = vector_q;
    assign int_id     = id_q;
    assign ret_pc     = ret_pc_q;
    assign pending    = pending_q;

endmodule
`default_nettype wire
